// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: widths,
// controller request encodings and FSM state encodings.
package icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_INDEX_BITS = 6;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

endpackage

// File: rtl/icache_if.sv
// Fetch-stage port and memory-controller instruction port of the icache.
// slave = the cache's view, master = the fetch stage plus controller.
interface icache_if
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_W,
    parameter int DATA_WIDTH = ICACHE_DATA_W
) ();

    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  flush;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_inst;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [1:0]            mem_rw_flag;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [1:0]            mem_len;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_busy;
    logic                  mem_done;

    modport slave (
        input  fetch_en, fetch_addr, flush, mem_data, mem_busy, mem_done,
        output fetch_valid, fetch_inst, fetch_pc, mem_rw_flag, mem_addr, mem_len
    );

    modport master (
        output fetch_en, fetch_addr, flush, mem_data, mem_busy, mem_done,
        input  fetch_valid, fetch_inst, fetch_pc, mem_rw_flag, mem_addr, mem_len
    );

endinterface

// File: rtl/icache_array.sv
// Tag/data storage (one write port, asynchronous read) and the per-line
// valid vector, which alone is cleared by reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_ADDR_W - ICACHE_INDEX_BITS - 2,
    parameter int DATA_WIDTH = ICACHE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int LINES = 32'd1 << INDEX_BITS;

    logic [TAG_BITS-1:0]   tag_arr_r  [LINES];
    logic [DATA_WIDTH-1:0] data_arr_r [LINES];
    logic [LINES-1:0]      valid_r;

    // Line fill: tag and data storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr_r[wr_index]  <= wr_tag;
            data_arr_r[wr_index] <= wr_data;
        end
    end

    // Valid bits: cleared asynchronously, set by a fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_arr_r[rd_index];
    assign rd_data  = data_arr_r[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines; misses are fetched
// through a single outstanding 4-byte read on the controller port.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_WIDTH = ICACHE_ADDR_W,
    parameter int DATA_WIDTH = ICACHE_DATA_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [1:0]            state_r;
    logic                  discard_r;
    logic [ADDR_WIDTH-1:0] miss_addr_r;
    logic                  fetch_valid_r;
    logic [DATA_WIDTH-1:0] fetch_inst_r;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [1:0]            mem_rw_flag_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [1:0]            mem_len_r;

    logic [ADDR_WIDTH-1:0] aligned_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  rd_valid_s;
    logic [TAG_BITS-1:0]   rd_tag_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  hit_s;
    logic                  fill_s;

    assign aligned_s = bus.fetch_addr & ALIGN_MASK;
    assign index_s   = bus.fetch_addr[INDEX_BITS+1:2];
    assign tag_s     = bus.fetch_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);
    // The fill is frozen with everything else while rdy is low.
    assign fill_s    = rdy && (state_r == ST_WAIT) && bus.mem_done;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (fill_s),
        .wr_index (miss_addr_r[INDEX_BITS+1:2]),
        .wr_tag   (miss_addr_r[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data  (bus.mem_data)
    );

    // Lookup/miss FSM with registered fetch response and controller request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            discard_r     <= 1'b0;
            miss_addr_r   <= '0;
            fetch_valid_r <= 1'b0;
            fetch_inst_r  <= '0;
            fetch_pc_r    <= '0;
            mem_rw_flag_r <= RW_NONE;
            mem_addr_r    <= '0;
            mem_len_r     <= 2'b00;
        end else if (rdy) begin
            fetch_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (bus.fetch_en && !bus.flush) begin
                        if (hit_s) begin
                            fetch_valid_r <= 1'b1;
                            fetch_inst_r  <= rd_data_s;
                            fetch_pc_r    <= aligned_s;
                        end else begin
                            miss_addr_r   <= aligned_s;
                            mem_rw_flag_r <= RW_READ;
                            mem_addr_r    <= aligned_s;
                            mem_len_r     <= LEN_WORD;
                            state_r       <= ST_ISSUE;
                        end
                    end
                end
                // The controller latches the request within this single cycle;
                // holding the flag longer would duplicate it.
                ST_ISSUE: begin
                    mem_rw_flag_r <= RW_NONE;
                    state_r       <= ST_WAIT;
                    if (bus.flush) begin
                        discard_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_done) begin
                        if (!discard_r && !bus.flush) begin
                            fetch_valid_r <= 1'b1;
                            fetch_inst_r  <= bus.mem_data;
                            fetch_pc_r    <= miss_addr_r;
                        end
                        discard_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (bus.flush) begin
                        discard_r <= 1'b1;
                    end
                end
                default: begin
                    discard_r     <= 1'b0;
                    mem_rw_flag_r <= RW_NONE;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_valid = fetch_valid_r;
    assign bus.fetch_inst  = fetch_inst_r;
    assign bus.fetch_pc    = fetch_pc_r;
    assign bus.mem_rw_flag = mem_rw_flag_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_len     = mem_len_r;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected fetch responses are queued when the
// request is driven and checked when fetch_valid pulses.
module tb_icache;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } resp_t;

    logic  clk;
    logic  rst;
    logic  rdy;
    int    n_vectors;
    int    n_miscompares;
    int    req_cnt;
    int    r0;
    resp_t exp_q[$];
    resp_t got_exp;

    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vectors = n_vectors + 1;
        if (act !== exp) begin
            n_miscompares = n_miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Response monitor: counts request cycles and pops the scoreboard.
    always @(negedge clk) begin
        if (bus.mem_rw_flag == 2'b10) req_cnt <= req_cnt + 1;
        if (bus.mem_rw_flag == 2'b01) chk("rw_write_flag", 64'(bus.mem_rw_flag), 64'd0);
        if (rst && bus.fetch_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'(bus.fetch_valid), 64'd0);
            end else begin
                got_exp = exp_q.pop_front();
                chk("resp_inst", 64'(bus.fetch_inst), 64'(got_exp.inst));
                chk("resp_pc", 64'(bus.fetch_pc), 64'(got_exp.pc));
            end
        end
    end

    task automatic issue_miss(input logic [31:0] addr);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = addr;
        @(negedge clk);
        bus.fetch_en = 1'b0;
        chk("miss_flag", 64'(bus.mem_rw_flag), 64'(2'b10));
        chk("miss_addr", 64'(bus.mem_addr), 64'(addr & 32'hFFFF_FFFC));
        chk("miss_len", 64'(bus.mem_len), 64'(2'b11));
        bus.mem_busy = 1'b1;
    endtask

    task automatic finish_miss(input logic [31:0] addr, input logic [31:0] data,
                               input int dly, input int flush_at, input logic resp);
        for (int i = 0; i < dly; i++) begin
            bus.flush = (i == flush_at);
            @(negedge clk);
            if (i == 0) chk("issue_one_cycle", 64'(bus.mem_rw_flag), 64'(2'b00));
        end
        bus.flush    = 1'b0;
        bus.mem_data = data;
        bus.mem_done = 1'b1;
        if (resp) exp_q.push_back('{inst: data, pc: addr & 32'hFFFF_FFFC});
        @(negedge clk);
        bus.mem_done = 1'b0;
        bus.mem_busy = 1'b0;
        chk("fill_valid", 64'(bus.fetch_valid), 64'(resp));
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] inst);
        exp_q.push_back('{inst: inst, pc: addr & 32'hFFFF_FFFC});
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = addr;
        @(negedge clk);
        bus.fetch_en = 1'b0;
        chk("hit_valid", 64'(bus.fetch_valid), 64'd1);
        chk("hit_no_req", 64'(bus.mem_rw_flag), 64'(2'b00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vectors      = 0;
        n_miscompares  = 0;
        req_cnt        = 0;
        rst            = 1'b0;
        rdy            = 1'b1;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.flush      = 1'b0;
        bus.mem_data   = 32'h0;
        bus.mem_busy   = 1'b0;
        bus.mem_done   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        chk("rst_fetch_inst", 64'(bus.fetch_inst), 64'd0);
        chk("rst_fetch_pc", 64'(bus.fetch_pc), 64'd0);
        chk("rst_rw_flag", 64'(bus.mem_rw_flag), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_len", 64'(bus.mem_len), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss, done five cycles after the request.
        issue_miss(32'h0000_0100);
        finish_miss(32'h0000_0100, 32'hDEAD_BEEF, 4, -1, 1'b1);

        // Hit with low address bits set, then alternating back-to-back hits.
        hit(32'h0000_0102, 32'hDEAD_BEEF);
        issue_miss(32'h0000_0104);
        finish_miss(32'h0000_0104, 32'hCAFE_F00D, 2, -1, 1'b1);
        r0 = req_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_en   = 1'b1;
            bus.fetch_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0104;
            exp_q.push_back('{inst: (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D,
                              pc: bus.fetch_addr});
            @(negedge clk);
        end
        bus.fetch_en = 1'b0;
        @(negedge clk);
        chk("alt_no_req", 64'(req_cnt - r0), 64'd0);
        chk("alt_drained", 64'(exp_q.size()), 64'd0);

        // Same-index conflict evicts and refills.
        issue_miss(32'h0000_0200);
        finish_miss(32'h0000_0200, 32'h0BAD_0200, 3, -1, 1'b1);
        hit(32'h0000_0200, 32'h0BAD_0200);
        issue_miss(32'h0000_0100);
        finish_miss(32'h0000_0100, 32'hDEAD_BEEF, 3, -1, 1'b1);

        // Flush during WAIT suppresses the response but the line still fills.
        issue_miss(32'h0000_0300);
        finish_miss(32'h0000_0300, 32'h1234_5678, 4, 2, 1'b0);
        hit(32'h0000_0300, 32'h1234_5678);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 32'h0000_0300;
        bus.flush      = 1'b1;
        @(negedge clk);
        bus.fetch_en = 1'b0;
        bus.flush    = 1'b0;
        chk("idle_flush", 64'(bus.fetch_valid), 64'd0);

        // rdy low in ISSUE holds the request; it drops one cycle after release.
        r0 = req_cnt;
        issue_miss(32'h0000_0400);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rdy_hold_flag", 64'(bus.mem_rw_flag), 64'(2'b10));
            chk("rdy_hold_addr", 64'(bus.mem_addr), 64'h400);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("rdy_release_flag", 64'(bus.mem_rw_flag), 64'(2'b00));
        chk("rdy_req_cycles", 64'(req_cnt - r0), 64'd4);
        finish_miss(32'h0000_0400, 32'h4444_4444, 1, -1, 1'b1);

        // Reset during WAIT: late done is dropped, cache lines are invalid.
        issue_miss(32'h0000_0500);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_flag", 64'(bus.mem_rw_flag), 64'd0);
        chk("midrst_addr", 64'(bus.mem_addr), 64'd0);
        @(negedge clk);
        rst          = 1'b1;
        bus.mem_busy = 1'b0;
        @(negedge clk);
        bus.mem_data = 32'h5555_5555;
        bus.mem_done = 1'b1;
        @(negedge clk);
        bus.mem_done = 1'b0;
        chk("late_done_dropped", 64'(bus.fetch_valid), 64'd0);
        issue_miss(32'h0000_0500);
        finish_miss(32'h0000_0500, 32'h5A5A_5A5A, 2, -1, 1'b1);
        issue_miss(32'h0000_0104);
        finish_miss(32'h0000_0104, 32'hCAFE_F00D, 2, -1, 1'b1);

        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache; the initiator on the instruction port of the byte-serial memory controller.
- Accepts PC fetches from the fetch stage.
- On a hit, returns the word with 1-cycle latency.
- On a miss, issues one 4-byte read request to the controller port, waits for the done pulse, fills the line and returns the word.
- Holds at most one outstanding memory request.

Parameters:
INDEX_BITS, 6, line index width (2^INDEX_BITS one-word lines)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction word width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; when low, all state frozen
fetch_en  in  1  fetch stage requests instruction at fetch_addr
fetch_addr  in  ADDR_WIDTH  byte PC; bits [1:0] ignored
flush  in  1  discard any in-progress/just-completing fetch result (branch redirect)
fetch_valid  out  1  one-cycle pulse: fetch_inst/fetch_pc valid
fetch_inst  out  DATA_WIDTH  returned instruction
fetch_pc  out  ADDR_WIDTH  word-aligned address of fetch_inst
mem_rw_flag  out  2  2'b10 = read, 2'b01 = write (never driven), 2'b00 = none
mem_addr  out  ADDR_WIDTH  request byte address (word-aligned)
mem_len  out  2  bytes-1; always 2'b11 when issuing
mem_data  in  DATA_WIDTH  controller read data for this port, little-endian bytes
mem_busy  in  1  controller holds a request for this port
mem_done  in  1  controller completion pulse for this port

Behaviour:
- Reset (rst low, async):
  - valid[] all cleared; state IDLE.
  - fetch_valid=0, fetch_inst=0, fetch_pc=0, mem_rw_flag=0, mem_addr=0, mem_len=0.
  - Tag/data arrays not reset.
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Hit = valid[index] && tag_arr[index]==tag. Lookup is combinational from fetch_addr.
- rdy low: no register changes, including state and outputs. While rdy low the registered mem_rw_flag is not updated: a request already presented stays asserted.
- States:
  - IDLE:
    - fetch_en && !flush && hit -> next cycle fetch_valid=1, fetch_inst=data_arr[index], fetch_pc={addr[31:2],2'b00}; stay IDLE. Back-to-back hits give one word per cycle.
    - fetch_en && !flush && miss -> latch miss_addr; register mem_rw_flag=2'b10, mem_addr=aligned addr, mem_len=2'b11; -> ISSUE. fetch_valid=0.
    - Otherwise fetch_valid=0.
    - mem_done in IDLE is ignored.
  - ISSUE (request visible for exactly one cycle): mem_rw_flag<=2'b00 -> WAIT. The controller latches on its own edge within this window; keeping the flag high longer would duplicate the request.
  - WAIT:
    - On mem_done=1: write data_arr[miss index]=mem_data, tag_arr=miss tag, valid=1.
    - If discard flag clear: fetch_valid=1, fetch_inst=mem_data, fetch_pc=miss_addr.
    - -> IDLE.
    - mem_busy is informational only; completion is mem_done alone.
- Discard flag:
  - Set by flush in ISSUE or WAIT.
  - Also set by flush in the same cycle mem_done is sampled.
  - Cleared on entry to IDLE.
  - The fill always completes and updates the array; only the response is suppressed.
- flush in IDLE: suppresses any response for that cycle; nothing pending.
- fetch_addr/fetch_en changes during ISSUE/WAIT are ignored. The result is always for miss_addr. The fetch stage compares fetch_pc.
- Same-index fill and next-cycle lookup: a fill written at edge N is visible to a hit lookup at edge N+1.
- Reset mid-miss: cache returns to IDLE with valid cleared. A later mem_done from the controller is dropped (IDLE ignores it).
- No write path; mem_rw_flag never 2'b01.

Decomposition:
- Shared package/defines: address width, data width, rw_flag encodings (RW_NONE=2'b00, RW_WRITE=2'b01, RW_READ=2'b10), LEN_WORD=2'b11, state encodings.
- One natural sub-module: icache_array, holding tag+data storage (single write port, async read) and the valid vector with async clear. The FSM stays in icache.

Test Plan:
1. Reset low mid-run, release; fetch_en, fetch_addr=0x0000_0100 -> miss. One-cycle mem_rw_flag=2'b10, mem_addr=0x100, mem_len=2'b11. Bench done after 5 cycles with mem_data=0xDEADBEEF -> next edge fetch_valid=1, fetch_inst=0xDEADBEEF, fetch_pc=0x100.
2. Re-fetch 0x102 after 1 -> hit, fetch_valid next cycle with 0xDEADBEEF, pc 0x100, no mem request. Fetch 0x104 and 0x100 alternately -> one valid per cycle once both are filled.
3. Conflict: fill 0x100, then fetch 0x200 (same index with INDEX_BITS=6) -> miss and refill. Fetch 0x100 again -> miss.
4. Miss on 0x300, assert flush during WAIT, done with 0x12345678 -> no fetch_valid. Next fetch 0x300 hits and returns 0x12345678.
5. rdy held low for 3 cycles in ISSUE -> mem_rw_flag stays 2'b10, state unchanged. After rdy returns -> flag high exactly one further cycle.
6. Assert rst during WAIT, deliver mem_done after release -> no fetch_valid. Fetch of same address misses again.
